reduce_unit: RTL and testbench
==============================

REDUCE_UNIT -- requirements
Module: reduce_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 3, bit width of each input word.
REQ-002 SHALL have parameter CNT_W, default 4, width of the beat counter and out_count.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  unit accepts a beat this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  input word.
REQ-008 SHALL have port in_last  input  1  beat is last of frame.
REQ-009 SHALL have port mode  input  3  op select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 NOR.
REQ-010 SHALL have port out_valid  output  1  frame result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_data  output  1  frame reduction result.
REQ-013 SHALL have port out_count  output  CNT_W  beats in the reported frame.

Function
REQ-014 SHALL treat a beat as accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-015 SHALL implement states IDLE (no frame open), ACCUM (frame open), HOLD (result waiting).
REQ-016 SHALL latch mode on the first accepted beat of a frame, ignoring mode changes until the frame ends.
REQ-017 SHALL reduce every beat's WIDTH bits with the base op (AND for 0/3, OR for 1/4/6/7, XOR for 2/5) and fold it into an accumulator seeded with the identity (AND 1, OR 0, XOR 0).
REQ-018 SHALL, on the accepted beat with in_last=1, register out_data = accumulator folded with that beat, inverted for modes 3-7, and assert out_valid on the next cycle (latency 1 from last beat).
REQ-019 SHALL handle a single-beat frame (in_last on first beat) identically; IDLE -> HOLD directly.
REQ-020 SHALL drive in_ready = !out_valid || out_ready; in_ready is 1 in IDLE and ACCUM.
REQ-021 SHALL hold out_data, out_count and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid when out_ready=1, unless a new last beat is accepted the same cycle, in which case the new result loads and out_valid stays 1.
REQ-023 SHALL allow the first beat of a new frame to be accepted in the same cycle a result is consumed.
REQ-024 SHALL count accepted beats per frame, saturating at 2^CNT_W-1, and present the count on out_count with the result.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, go to IDLE, set out_valid=0, out_data=0, out_count=0, clear accumulator and counter.
REQ-026 SHALL discard any open frame or pending result on reset; no partial result is ever output.
REQ-027 SHALL give rst priority over any simultaneous accepted beat.

Configuration
REQ-028 SHALL, with REDUCE_UNIT_BEAT_COUNT_EN defined, implement the beat counter and drive out_count per REQ-024.
REQ-029 SHALL, without REDUCE_UNIT_BEAT_COUNT_EN, omit the counter and tie out_count to 0; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: mode=4, single beat in_data=3'b000, last=1 -> next cycle out_valid=1, out_data=1, out_count=1.
REQ-031 SHALL cover: mode=2, beats 3'b011, 3'b001, 3'b111(last) -> out_data=0 (0^1^1), out_count=3.
REQ-032 SHALL cover: mode=3 latched on beat 1 (3'b111), mode changed to 1 on beat 2 (3'b110, last) -> out_data=1 (NAND of all).
REQ-033 SHALL cover: out_ready=0 for 5 cycles after result -> in_ready=0, out_data/out_count stable; out_ready=1 with last beat same cycle -> new result loaded, out_valid stays 1.
REQ-034 SHALL cover: rst=1 mid-frame after 2 beats -> out_valid=0, out_count=0; next frame mode=0 beat 3'b111 last -> out_data=1, out_count=1.
REQ-035 SHALL cover: CNT_W=2, 6-beat frame -> out_count=3 (saturated); build without macro -> out_count=0.

Source files
------------

// File: rtl/reduce_unit.sv
// reduce_unit: folds every beat of a valid/ready frame into one result bit.
//
// Each beat's WIDTH bits are reduced with the base op of the frame's mode:
//   AND for modes 0 and 3, XOR for modes 2 and 5, OR for modes 1, 4, 6 and 7.
// The per-beat bits are then folded into an accumulator using the same op.
// Modes 3-7 invert the final result.
// The mode is captured on the first beat of a frame. The result for the beat
// with in_last=1 is registered and presented one cycle later. It is held
// until out_ready is seen high.
//
// Optional feature: define REDUCE_UNIT_BEAT_COUNT_EN to count accepted beats
// per frame. The count saturates at 2**CNT_W-1 and is reported on out_count.
// Without the macro, out_count is tied to 0.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - input beat valid
//   in_ready  - unit accepts a beat this cycle
//   in_data   - input word, WIDTH bits
//   in_last   - beat is last of its frame
//   mode      - op select, captured on the first beat of a frame
//   out_valid - frame result valid
//   out_ready - downstream accepts the result
//   out_data  - frame reduction result
//   out_count - beats in the reported frame, CNT_W bits
module reduce_unit #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic       acc_q, acc_d;
    logic       out_valid_q, out_valid_d;
    logic       out_data_q, out_data_d;

    logic       accept;
    logic       first_beat;
    logic [2:0] eff_mode;
    logic       sel_and, sel_xor;
    logic       beat_red;
    logic       fold;
    logic       result;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Any beat that arrives outside ACCUM opens a new frame.
    assign first_beat = (state_q != StAccum);
    assign eff_mode   = first_beat ? mode : mode_q;

    always_comb begin
        sel_and = (eff_mode == 3'd0) || (eff_mode == 3'd3);
        sel_xor = (eff_mode == 3'd2) || (eff_mode == 3'd5);

        if (sel_and) begin
            beat_red = &in_data;
        end else if (sel_xor) begin
            beat_red = ^in_data;
        end else begin
            beat_red = |in_data;
        end

        // Folding into the identity is the beat itself.
        if (first_beat) begin
            fold = beat_red;
        end else if (sel_and) begin
            fold = acc_q & beat_red;
        end else if (sel_xor) begin
            fold = acc_q ^ beat_red;
        end else begin
            fold = acc_q | beat_red;
        end

        result = fold ^ (eff_mode >= 3'd3);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (state_q == StHold) begin
                state_d = StIdle;
            end
        end

        if (accept) begin
            if (in_last) begin
                out_valid_d = 1'b1;
                out_data_d  = result;
                acc_d       = 1'b0;
                state_d     = StHold;
            end else begin
                acc_d   = fold;
                mode_d  = eff_mode;
                state_d = StAccum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 3'd0;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef REDUCE_UNIT_BEAT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        if (first_beat) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + CNT_W'(1);
        end

        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        if (accept) begin
            if (in_last) begin
                out_count_d = cnt_next;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_reduce_unit.sv
// Self-checking bench for reduce_unit. There are two instances, one with
// default parameters and one with CNT_W=2, and both share the same stimulus.
// Expected results come from a frame-level model. The model stores a frame's
// beats in a queue and reduces all of their bits at once when the last beat
// arrives.
module tb_reduce_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;
    logic       in_last = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_data_a;
    logic [3:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_data_b;
    logic [1:0] out_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_unit #(.WIDTH(3), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready_a),
        .in_data  (in_data),
        .in_last  (in_last),
        .mode     (mode),
        .out_valid(out_valid_a),
        .out_ready(out_ready),
        .out_data (out_data_a),
        .out_count(out_count_a)
    );

    reduce_unit #(.WIDTH(3), .CNT_W(2)) dut_c2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready_b),
        .in_data  (in_data),
        .in_last  (in_last),
        .mode     (mode),
        .out_valid(out_valid_b),
        .out_ready(out_ready),
        .out_data (out_data_b),
        .out_count(out_count_b)
    );

    // Reference state
    logic [2:0] frame_q[$];
    logic [2:0] frame_mode;
    bit         pend_valid;
    bit         pend_data;
    int         pend_beats;
    bit         rst_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reduce_frame(input logic [2:0] m, input int n);
        int ones = 0;
        int bits = n * 3;
        bit r;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (frame_q[i][b]) ones++;
            end
        end
        case (m)
            3'd0, 3'd3: r = (ones == bits);
            3'd2, 3'd5: r = ones[0];
            default:    r = (ones != 0);
        endcase
        return (m >= 3'd3) ? !r : r;
    endfunction

    function automatic int exp_count(input int n, input int cnt_w);
`ifdef REDUCE_UNIT_BEAT_COUNT_EN
        int lim = (1 << cnt_w) - 1;
        return (n > lim) ? lim : n;
`else
        return 0;
`endif
    endfunction

    // Runs one clock cycle: drives at the falling edge, updates the model at
    // the rising edge, then checks the registered outputs at the next falling edge.
    task automatic cycle(input bit r, input bit v, input logic [2:0] d, input bit l,
                         input logic [2:0] m, input bit ordy);
        bit exp_rdy;
        bit acc;
        rst = r; in_valid = v; in_data = d; in_last = l; mode = m; out_ready = ordy;
        exp_rdy = !pend_valid || ordy;
        #1;
        check_eq("in_ready", in_ready_a, exp_rdy);
        check_eq("in_ready_c2", in_ready_b, exp_rdy);
        @(posedge clk);
        acc = v && exp_rdy;
        if (r) begin
            frame_q.delete();
            pend_valid = 0;
            pend_data  = 0;
            pend_beats = 0;
        end else begin
            if (pend_valid && ordy) pend_valid = 0;
            if (acc) begin
                if (frame_q.size() == 0) frame_mode = m;
                frame_q.push_back(d);
                if (l) begin
                    pend_valid = 1;
                    pend_beats = frame_q.size();
                    pend_data  = reduce_frame(frame_mode, frame_q.size());
                    frame_q.delete();
                end
            end
        end
        @(negedge clk);
        check_eq("out_valid", out_valid_a, pend_valid);
        check_eq("out_valid_c2", out_valid_b, pend_valid);
        if (pend_valid || r) begin
            check_eq("out_data", out_data_a, pend_data);
            check_eq("out_data_c2", out_data_b, pend_data);
            check_eq("out_count", out_count_a, exp_count(pend_beats, 4));
            check_eq("out_count_c2", out_count_b, exp_count(pend_beats, 2));
        end
        rst_prev = r;
    endtask

    initial begin
        pend_valid = 0; pend_data = 0; pend_beats = 0; frame_mode = 0; rst_prev = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        cycle(1, 0, 3'd0, 0, 3'd0, 0);

        // mode 4 single beat 000 -> 1, count 1
        cycle(0, 1, 3'b000, 1, 3'd4, 1);
        check_eq("nor_single", out_data_a, 1'b1);
        cycle(0, 0, 3'd0, 0, 3'd0, 1);

        // mode 2: 011, 001, 111 -> 0, count 3
        cycle(0, 1, 3'b011, 0, 3'd2, 1);
        cycle(0, 1, 3'b001, 0, 3'd2, 1);
        cycle(0, 1, 3'b111, 1, 3'd2, 1);
        check_eq("xor_frame", out_data_a, 1'b0);
        cycle(0, 0, 3'd0, 0, 3'd0, 1);

        // Mode latched as 3 and changed on the second beat -> NAND of all = 1
        cycle(0, 1, 3'b111, 0, 3'd3, 1);
        cycle(0, 1, 3'b110, 1, 3'd1, 1);
        check_eq("mode_latch", out_data_a, 1'b1);

        // Backpressure for 5 cycles, then consume and load a new last beat in the same cycle
        for (int i = 0; i < 5; i++) cycle(0, 1, 3'b000, 1, 3'd0, 0);
        cycle(0, 1, 3'b101, 1, 3'd1, 1);
        check_eq("swap_valid", out_valid_a, 1'b1);
        cycle(0, 0, 3'd0, 0, 3'd0, 1);

        // Reset mid-frame after 2 beats, then mode 0 single beat 111
        cycle(0, 1, 3'b111, 0, 3'd0, 1);
        cycle(0, 1, 3'b111, 0, 3'd0, 1);
        cycle(1, 1, 3'b111, 1, 3'd0, 1);
        cycle(0, 1, 3'b111, 1, 3'd0, 1);
        cycle(0, 0, 3'd0, 0, 3'd0, 1);

        // 6-beat frame; the CNT_W=2 instance saturates at 3
        for (int i = 0; i < 6; i++) cycle(0, 1, 3'b010, (i == 5), 3'd1, 1);
        cycle(0, 0, 3'd0, 0, 3'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  3'($urandom),
                  ($urandom_range(0, 9) < 3),
                  3'($urandom),
                  ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
